// File: rtl/lcd_responder.sv
// lcd_responder: HD44780-style panel model with an 80-byte DDRAM, busy timing, status/data reads
// and a registered DDRAM read port for mirroring.
module lcd_responder #(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_en,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  output logic       busy,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic [6:0] cursor_addr,
  output logic [5:0] disp_shift,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_char,
  output logic       proto_err
);
  localparam int MAXC = BUSY_CYCLES > CLEAR_CYCLES ? BUSY_CYCLES : CLEAR_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic [1:0] {RESET_CLEAR, IDLE, BUSY, CLEAR} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0] clr_q, clr_d, ac_q, ac_d;
  logic [5:0] sh_q, sh_d;
  logic disp_q, disp_d, cur_q, cur_d, blink_q, blink_d, tl_q, tl_d;
  logic id_q, id_d, es_q, es_d, perr_q, perr_d, oe_q, oe_d;
  logic [7:0] dout_q, dout_d, rdc_q, rdc_d;
  logic [2:0] en_q;
  logic [1:0] rs_q, rw_q;
  logic [7:0] dat1_q, dat2_q;
  logic [7:0] mem [80];
  logic [7:0] ac_m, rd_m, new_m, ac_byte, wd;
  logic [6:0] wa;
  logic fall, rise, we;

  // {valid, physical index}; physical index = line*40 + col
  function automatic logic [7:0] map_addr(input logic [6:0] a, input logic tl);
    if (!tl) return (a <= 7'h4F) ? {1'b1, a} : 8'h00;
    if (a <= 7'h27) return {1'b1, a};
    return (a >= 7'h40 && a <= 7'h67) ? {1'b1, a - 7'd24} : 8'h00;
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up, input logic tl);
    if (up) return tl ? (a == 7'h27 ? 7'h40 : a == 7'h67 ? 7'h00 : a + 7'd1)
                      : (a == 7'h4F ? 7'h00 : a + 7'd1);
    return tl ? (a == 7'h40 ? 7'h27 : a == 7'h00 ? 7'h67 : a - 7'd1)
              : (a == 7'h00 ? 7'h4F : a - 7'd1);
  endfunction

  function automatic logic [5:0] sh_step(input logic [5:0] s, input logic up);
    return up ? (s == 6'd39 ? 6'd0 : s + 6'd1) : (s == 6'd0 ? 6'd39 : s - 6'd1);
  endfunction

  assign fall    = en_q[2] & ~en_q[1];
  assign rise    = en_q[0] & ~en_q[1];
  assign ac_m    = map_addr(ac_q, tl_q);
  assign rd_m    = map_addr(rd_addr, tl_q);
  assign new_m   = map_addr(dat2_q[6:0], tl_q);
  assign ac_byte = ac_m[7] ? mem[ac_m[6:0]] : 8'h20;
  assign busy    = state_q != IDLE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_d   = clr_q;
    ac_d    = ac_q;
    sh_d    = sh_q;
    disp_d  = disp_q;
    cur_d   = cur_q;
    blink_d = blink_q;
    tl_d    = tl_q;
    id_d    = id_q;
    es_d    = es_q;
    we      = 1'b0;
    wa      = ac_m[6:0];
    wd      = dat2_q;
    perr_d  = perr_q | (fall & busy & (~rw_q[1] | rs_q[1]));
    oe_d    = en_q[0] & rw_q[0];
    dout_d  = (rise & rw_q[0]) ? (rs_q[0] ? ac_byte : {busy, ac_q}) : dout_q;
    rdc_d   = rd_m[7] ? mem[rd_m[6:0]] : 8'h20;
    case (state_q)
      RESET_CLEAR, CLEAR: begin
        we    = 1'b1;
        wa    = clr_q;
        wd    = 8'h20;
        clr_d = clr_q + 7'd1;
        if (state_q == CLEAR) cnt_d = cnt_q - CW'(1);
        if (clr_q == 7'd79) begin
          clr_d   = 7'd0;
          state_d = (state_q == RESET_CLEAR || cnt_q == '0) ? IDLE : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = IDLE;
      end
      default: if (fall && !(rw_q[1] && !rs_q[1])) begin
        state_d = BUSY;
        cnt_d   = CW'(BUSY_CYCLES - 1);
        if (rs_q[1]) begin
          ac_d = ac_step(ac_q, id_q, tl_q);
          if (!rw_q[1]) begin
            we = ac_m[7];
            if (es_q) sh_d = sh_step(sh_q, id_q);
          end
        end else if (dat2_q[7]) begin
          ac_d   = new_m[7] ? dat2_q[6:0] : 7'd0;
          perr_d = perr_q | ~new_m[7];
        end else if (dat2_q[6]) begin
        end else if (dat2_q[5]) begin
          tl_d = dat2_q[3];
        end else if (dat2_q[4]) begin
          if (dat2_q[3]) sh_d = sh_step(sh_q, dat2_q[2]);
          else ac_d = ac_step(ac_q, dat2_q[2], tl_q);
        end else if (dat2_q[3]) begin
          {disp_d, cur_d, blink_d} = dat2_q[2:0];
        end else if (dat2_q[2]) begin
          {id_d, es_d} = dat2_q[1:0];
        end else if (dat2_q[1] | dat2_q[0]) begin
          ac_d  = 7'd0;
          sh_d  = 6'd0;
          cnt_d = CW'(CLEAR_CYCLES - 1);
          if (!dat2_q[1]) begin
            id_d    = 1'b1;
            clr_d   = 7'd0;
            state_d = CLEAR;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) if (we) mem[wa] <= wd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_CLEAR;
      cnt_q   <= '0;
      clr_q   <= 7'd0;
      ac_q    <= 7'd0;
      sh_q    <= 6'd0;
      disp_q  <= 1'b0;
      cur_q   <= 1'b0;
      blink_q <= 1'b0;
      tl_q    <= 1'b0;
      id_q    <= 1'b1;
      es_q    <= 1'b0;
      perr_q  <= 1'b0;
      oe_q    <= 1'b0;
      dout_q  <= 8'h00;
      rdc_q   <= 8'h00;
      en_q    <= 3'b000;
      rs_q    <= 2'b00;
      rw_q    <= 2'b00;
      dat1_q  <= 8'h00;
      dat2_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
      ac_q    <= ac_d;
      sh_q    <= sh_d;
      disp_q  <= disp_d;
      cur_q   <= cur_d;
      blink_q <= blink_d;
      tl_q    <= tl_d;
      id_q    <= id_d;
      es_q    <= es_d;
      perr_q  <= perr_d;
      oe_q    <= oe_d;
      dout_q  <= dout_d;
      rdc_q   <= rdc_d;
      en_q    <= {en_q[1:0], lcd_en};
      rs_q    <= {rs_q[0], lcd_rs};
      rw_q    <= {rw_q[0], lcd_rw};
      dat1_q  <= lcd_data_in;
      dat2_q  <= dat1_q;
    end
  end

  assign lcd_data_out = dout_q;
  assign lcd_data_oe  = oe_q;
  assign display_on   = disp_q;
  assign cursor_on    = cur_q;
  assign blink_on     = blink_q;
  assign two_line     = tl_q;
  assign cursor_addr  = ac_q;
  assign disp_shift   = sh_q;
  assign rd_char      = rdc_q;
  assign proto_err    = perr_q;
endmodule
